psum_accum_mem: RTL



---
 rtl/psum_accum_mem_if.sv | 31 +++
 rtl/psum_accum_mem.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/psum_accum_mem_if.sv
// Bus bundle for the partial-sum accumulation memory: write/read requests,
// clear pulse, and the read/row-sum/status responses.
interface psum_accum_mem_if #(
  parameter int col     = 8,
  parameter int bw_psum = 20,
  parameter int addr_w  = 4
);
  logic                   in_valid;
  logic [bw_psum*col-1:0] in;
  logic [addr_w-1:0]      wr_add;
  logic                   acc_mode;
  logic                   rd_en;
  logic [addr_w-1:0]      rd_add;
  logic                   clr;
  logic [bw_psum*col-1:0] out;
  logic                   out_valid;
  logic [bw_psum+3:0]     sum_out;
  logic                   sum_valid;
  logic                   busy;
  logic                   sat_flag;

  modport master (
    output in_valid, in, wr_add, acc_mode, rd_en, rd_add, clr,
    input  out, out_valid, sum_out, sum_valid, busy, sat_flag
  );

  modport slave (
    input  in_valid, in, wr_add, acc_mode, rd_en, rd_add, clr,
    output out, out_valid, sum_out, sum_valid, busy, sat_flag
  );
endinterface

// File: rtl/psum_accum_mem.sv
// Partial-sum row memory with overwrite/saturating-accumulate writes, a
// forwarded read port, a pipelined |psum| row sum and a background clear sweep.
module psum_accum_mem #(
  parameter int col     = 8,
  parameter int bw_psum = 20,
  parameter int depth   = 16,
  parameter int addr_w  = 4
) (
  input  logic             clk,
  input  logic             reset,
  psum_accum_mem_if.slave  bus
);
  localparam int RW = bw_psum * col;
  localparam int SW = bw_psum + 4;
  localparam logic [addr_w:0]   DEPTH_W  = (addr_w + 1)'(depth);
  localparam logic [addr_w-1:0] LAST_ADD = addr_w'(depth - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            r_state, w_state_next;
  logic [addr_w-1:0] r_clr_cnt;
  logic [RW-1:0]     r_mem [depth];

  logic              r_s1_valid;
  logic              r_s1_acc;
  logic [addr_w-1:0] r_s1_add;
  logic [RW-1:0]     r_s1_data;
  logic [RW-1:0]     r_s1_old;

  logic [RW-1:0]     r_out;
  logic              r_out_valid;
  logic [SW-1:0]     r_sum;
  logic              r_sum_valid;
  logic              r_sat;

  logic              w_busy;
  logic              w_clr_start;
  logic              w_wr_accept;
  logic              w_rd_accept;
  logic [RW-1:0]     w_wr_old;
  logic [RW-1:0]     w_rd_row;
  logic [RW-1:0]     w_s1_result;
  logic              w_s1_sat;
  logic [bw_psum:0]  w_lane_sum;
  logic [SW-1:0]     w_lane_abs;
  logic [SW-1:0]     w_row_sum;

  assign w_busy      = (r_state == SWEEP);
  assign w_clr_start = bus.clr && !w_busy;
  assign w_wr_accept = bus.in_valid && !w_busy && !w_clr_start &&
                       ({1'b0, bus.wr_add} < DEPTH_W);
  assign w_rd_accept = bus.rd_en && !w_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.clr) w_state_next = SWEEP;
      SWEEP:   if (r_clr_cnt == LAST_ADD) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_clr_cnt <= '0;
    else if (w_busy) r_clr_cnt <= r_clr_cnt + addr_w'(1);
    else             r_clr_cnt <= '0;
  end

  // The only uncommitted write lives in stage 1, so both the accumulate
  // operand and the read port bypass the array with its result on a hit.
  always_comb begin
    w_wr_old = r_mem[bus.wr_add];
    if (r_s1_valid && (r_s1_add == bus.wr_add)) w_wr_old = w_s1_result;
    w_rd_row = '0;
    if ({1'b0, bus.rd_add} < DEPTH_W) begin
      w_rd_row = r_mem[bus.rd_add];
      if (r_s1_valid && (r_s1_add == bus.rd_add)) w_rd_row = w_s1_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_acc   <= 1'b0;
      r_s1_add   <= '0;
      r_s1_data  <= '0;
      r_s1_old   <= '0;
    end else begin
      r_s1_valid <= w_wr_accept;
      if (w_wr_accept) begin
        r_s1_acc  <= bus.acc_mode;
        r_s1_add  <= bus.wr_add;
        r_s1_data <= bus.in;
        r_s1_old  <= w_wr_old;
      end
    end
  end

  // Overflow shows as disagreement between the two top bits of the widened sum.
  always_comb begin
    w_s1_result = r_s1_data;
    w_s1_sat    = 1'b0;
    w_lane_sum  = '0;
    if (r_s1_acc) begin
      for (int i = 0; i < col; i++) begin
        w_lane_sum = {r_s1_old[i*bw_psum+bw_psum-1], r_s1_old[i*bw_psum +: bw_psum]} +
                     {r_s1_data[i*bw_psum+bw_psum-1], r_s1_data[i*bw_psum +: bw_psum]};
        if (w_lane_sum[bw_psum] != w_lane_sum[bw_psum-1]) begin
          w_s1_sat = 1'b1;
          w_s1_result[i*bw_psum +: bw_psum] = w_lane_sum[bw_psum] ?
            {1'b1, {(bw_psum-1){1'b0}}} : {1'b0, {(bw_psum-1){1'b1}}};
        end else begin
          w_s1_result[i*bw_psum +: bw_psum] = w_lane_sum[bw_psum-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) r_mem[i] <= '0;
    end else if (w_busy) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (r_s1_valid && !w_clr_start) begin
      r_mem[r_s1_add] <= w_s1_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_sat <= 1'b0;
    else if (w_clr_start)             r_sat <= 1'b0;
    else if (r_s1_valid && w_s1_sat)  r_sat <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_rd_accept;
      if (w_rd_accept) r_out <= w_rd_row;
    end
  end

  // Lanes are sign-extended to the sum width before negation so that the
  // most-negative psum yields its true magnitude.
  always_comb begin
    w_row_sum  = '0;
    w_lane_abs = '0;
    for (int i = 0; i < col; i++) begin
      w_lane_abs = {{4{r_out[i*bw_psum+bw_psum-1]}}, r_out[i*bw_psum +: bw_psum]};
      if (r_out[i*bw_psum+bw_psum-1]) w_lane_abs = -w_lane_abs;
      w_row_sum = w_row_sum + w_lane_abs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      r_sum_valid <= r_out_valid;
      if (r_out_valid) r_sum <= w_row_sum;
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.sum_out   = r_sum;
  assign bus.sum_valid = r_sum_valid;
  assign bus.busy      = w_busy;
  assign bus.sat_flag  = r_sat;
endmodule
